// File: rtl/vector_write_back_pkg.sv
// Shared encodings for the vector write-back stage: register file commands,
// register file status codes and the sequencer state encoding.
package vector_write_back_pkg;

  localparam int unsigned RD_W     = 5;
  localparam int unsigned RF_CMD_W = 2;

  localparam logic [RF_CMD_W-1:0] VECTOR_RF_NOP   = 2'd0;
  localparam logic [RF_CMD_W-1:0] VECTOR_RF_WRITE = 2'd1;

  localparam logic [RF_CMD_W-1:0] RF_NOP      = 2'd0;
  localparam logic [RF_CMD_W-1:0] RF_FINISHED = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } vwb_state_e;

endpackage

// File: rtl/vwb_request_fifo.sv
// Small request buffer for the write-back stage; keeps each entry's rd and valid
// bit visible so the hazard check can see every outstanding destination.
module vwb_request_fifo
  import vector_write_back_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned LEN_W  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [RD_W-1:0]               wr_rd_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic [LEN_W-1:0]              wr_len_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [RD_W-1:0]               head_rd_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic [LEN_W-1:0]              head_len_o,
  output logic [DEPTH-1:0][RD_W-1:0]    entry_rd_o,
  output logic [DEPTH-1:0]              entry_valid_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [RD_W-1:0]   rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [LEN_W-1:0]  len_q  [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok_c, pop_ok_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok_c = push_i && !full_o;
  assign pop_ok_c  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
        len_q[i]  <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_c) begin
        rd_q[wr_ptr_q]    <= wr_rd_i;
        data_q[wr_ptr_q]  <= wr_data_i;
        len_q[wr_ptr_q]   <= wr_len_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      // Push and pop never target the same slot: push needs !full, pop needs !empty.
      if (pop_ok_c) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  assign head_rd_o   = rd_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign head_len_o  = len_q[rd_ptr_q];

  always_comb begin
    entry_rd_o    = '0;
    entry_valid_o = valid_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_rd_o[i] = rd_q[i];
    end
  end

endmodule

// File: rtl/vector_write_back.sv
// Vector write-back stage: buffers results, issues one register file write per
// request and retires it on RF completion. Define VWB_MASK_EN for masked merge.
module vector_write_back
  import vector_write_back_pkg::*;
#(
  parameter int unsigned LEN              = 32,
  parameter int unsigned VECTOR_SIZE      = 8,
  parameter int unsigned ENTRY_INDEX_SIZE = 3,
  parameter int unsigned FIFO_DEPTH       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [RD_W-1:0]               in_rd,
  input  logic [VECTOR_SIZE*LEN-1:0]    in_data,
  input  logic [VECTOR_SIZE*LEN-1:0]    in_old,
  input  logic [VECTOR_SIZE-1:0]        in_mask,
  input  logic [ENTRY_INDEX_SIZE-1:0]   in_length,
  output logic [RF_CMD_W-1:0]           rf_signal,
  output logic [RD_W-1:0]               rd,
  output logic [VECTOR_SIZE*LEN-1:0]    data,
  output logic [ENTRY_INDEX_SIZE-1:0]   length,
  output logic                          write_back_enabled,
  input  logic [RF_CMD_W-1:0]           rf_status,
  output logic                          wb_done,
  input  logic [RD_W-1:0]               query_rs,
  output logic                          hazard
);

  localparam int unsigned DATA_W = VECTOR_SIZE * LEN;

  vwb_state_e                    state_q, state_d;
  logic [RF_CMD_W-1:0]           rf_signal_q, rf_signal_d;
  logic [RD_W-1:0]               rd_q, rd_d;
  logic [DATA_W-1:0]             data_q, data_d;
  logic [ENTRY_INDEX_SIZE-1:0]   length_q, length_d;
  logic                          wbe_q, wbe_d;
  logic                          wb_done_q, wb_done_d;

  logic                          fifo_full_c, fifo_empty_c;
  logic [RD_W-1:0]               head_rd_c;
  logic [DATA_W-1:0]             head_data_c;
  logic [ENTRY_INDEX_SIZE-1:0]   head_len_c;
  logic [FIFO_DEPTH-1:0][RD_W-1:0] entry_rd_c;
  logic [FIFO_DEPTH-1:0]         entry_valid_c;
  logic                          push_c, pop_c, fsm_pop_c, hazard_c;
  logic [DATA_W-1:0]             enq_data_c;

`ifdef VWB_MASK_EN
  // Merge at enqueue so the buffer only ever stores the final write data.
  always_comb begin
    enq_data_c = in_old;
    for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
      if (in_mask[i]) enq_data_c[i*LEN +: LEN] = in_data[i*LEN +: LEN];
    end
  end
`else
  logic unused_c;
  assign enq_data_c = in_data;
  assign unused_c   = ^{in_mask, in_old};
`endif

  assign in_ready = rdy_in && !fifo_full_c;
  assign push_c   = in_valid && in_ready;
  assign pop_c    = fsm_pop_c && rdy_in;

  vwb_request_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W),
    .LEN_W  (ENTRY_INDEX_SIZE)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst),
    .push_i        (push_c),
    .pop_i         (pop_c),
    .wr_rd_i       (in_rd),
    .wr_data_i     (enq_data_c),
    .wr_len_i      (in_length),
    .full_o        (fifo_full_c),
    .empty_o       (fifo_empty_c),
    .head_rd_o     (head_rd_c),
    .head_data_o   (head_data_c),
    .head_len_o    (head_len_c),
    .entry_rd_o    (entry_rd_c),
    .entry_valid_o (entry_valid_c)
  );

  // Next state; RF outputs are registered so they line up with the WRITE state.
  always_comb begin
    state_d     = state_q;
    rf_signal_d = VECTOR_RF_NOP;
    wbe_d       = 1'b0;
    rd_d        = rd_q;
    data_d      = data_q;
    length_d    = length_q;
    wb_done_d   = 1'b0;
    fsm_pop_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_c) begin
          if (head_len_c != '0) begin
            state_d     = ST_WRITE;
            rf_signal_d = VECTOR_RF_WRITE;
            wbe_d       = 1'b1;
            rd_d        = head_rd_c;
            data_d      = head_data_c;
            length_d    = head_len_c;
          end else begin
            fsm_pop_c = 1'b1;
            wb_done_d = 1'b1;
          end
        end
      end
      ST_WRITE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rf_status == RF_FINISHED) begin
          state_d   = ST_IDLE;
          fsm_pop_c = 1'b1;
          wb_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rf_signal_q <= VECTOR_RF_NOP;
      wbe_q       <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      length_q    <= '0;
      wb_done_q   <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      rf_signal_q <= rf_signal_d;
      wbe_q       <= wbe_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      length_q    <= length_d;
      wb_done_q   <= wb_done_d;
    end
  end

  always_comb begin
    hazard_c = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid_c[i] && (entry_rd_c[i] == query_rs)) hazard_c = 1'b1;
    end
  end

  assign rf_signal          = rf_signal_q;
  assign write_back_enabled = wbe_q;
  assign rd                 = rd_q;
  assign data               = data_q;
  assign length             = length_q;
  // A pending pulse is held, not lost, while stalled and shows once rdy_in returns.
  assign wb_done            = wb_done_q && rdy_in;
  assign hazard             = hazard_c;

endmodule

// File: doc/vector_write_back.md
VECTOR_WRITE_BACK -- requirements
Module: vector_write_back

Interface
REQ-001 Parameters SHALL be: LEN=32 (element bits); VECTOR_SIZE=8 (elements per vector); ENTRY_INDEX_SIZE=3 (length field width); FIFO_DEPTH=2 (request buffer entries).
REQ-002 Ports SHALL be:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-low (0 = reset)
- rdy_in  in  1  global enable; when 0 all state holds
- in_valid  in  1  write-back request valid
- in_ready  out  1  request accepted when in_valid&&in_ready at clk edge
- in_rd  in  5  destination vector register index
- in_data  in  VECTOR_SIZE*LEN  result vector
- in_old  in  VECTOR_SIZE*LEN  current rd contents, used for mask merge
- in_mask  in  VECTOR_SIZE  per-element enable, bit i covers element i
- in_length  in  ENTRY_INDEX_SIZE  elements to write, starting at element 0
- rf_signal  out  2  register file command, VECTOR_RF_WRITE or VECTOR_RF_NOP
- rd  out  5  register file write index
- data  out  VECTOR_SIZE*LEN  register file write data
- length  out  ENTRY_INDEX_SIZE  register file write length
- write_back_enabled  out  1  register file write strobe
- rf_status  in  2  register file status, RF_NOP or RF_FINISHED
- wb_done  out  1  one-cycle pulse per retired request
- query_rs  in  5  register index to check for pending writes
- hazard  out  1  query_rs matches the rd of any buffered or in-flight request

Function
REQ-003 Requests SHALL enter a FIFO_DEPTH-entry FIFO; in_ready SHALL equal !full combinationally; there SHALL be no same-cycle bypass when full.
REQ-004 The FSM SHALL have states IDLE, WRITE and WAIT, and SHALL reset to IDLE.
REQ-005 In IDLE with the FIFO non-empty and head length != 0, the FSM SHALL go to WRITE next cycle.
REQ-006 In IDLE with head length == 0, the FSM SHALL pop the head, pulse wb_done the next cycle, issue no register file write, and stay in IDLE.
REQ-007 In WRITE, the block SHALL, for exactly one cycle, drive rf_signal=VECTOR_RF_WRITE, write_back_enabled=1, and rd/data/length from the FIFO head, then go to WAIT.
REQ-008 In all states other than WRITE, the block SHALL drive rf_signal=VECTOR_RF_NOP and write_back_enabled=0; rd, data and length SHALL hold their last values.
REQ-009 In WAIT, the FSM SHALL stay in WAIT until rf_status==RF_FINISHED, then pop the head, pulse wb_done (registered, next cycle) and return to IDLE.
REQ-010 Latency SHALL be: a request accepted at edge N drives WRITE during cycle N+1 (FIFO previously empty, FSM in IDLE).
REQ-011 Throughput SHALL be at most one register file write per 3 cycles.
REQ-012 Request order SHALL be preserved FIFO-wise, including repeated writes to the same rd.
REQ-013 hazard SHALL be combinational and SHALL cover every valid FIFO entry, including the head while in WRITE or WAIT; it SHALL deassert in the cycle after the pop.
REQ-014 When rdy_in=0, the FIFO, FSM and all outputs SHALL hold; in_ready SHALL read 0; wb_done SHALL read 0.
REQ-015 A simultaneous push and pop SHALL both take effect, leaving the occupancy count unchanged.

Reset
REQ-016 On rst=0 (asynchronous), the block SHALL set: FIFO empty; state IDLE; rf_signal=VECTOR_RF_NOP; write_back_enabled=0; rd=0; data=0; length=0; wb_done=0.
REQ-017 Reset mid-WAIT or mid-WRITE SHALL discard all buffered requests with no wb_done pulse.

Configuration
REQ-018 With VWB_MASK_EN defined, data element i SHALL be in_mask[i] ? in_data[i] : in_old[i], with the merge computed at enqueue.
REQ-019 Without VWB_MASK_EN, data SHALL equal in_data; in_mask and in_old SHALL be ignored and their FIFO storage omitted.

Structure
REQ-020 VECTOR_RF_WRITE, VECTOR_RF_NOP, RF_NOP, RF_FINISHED and the FSM state encodings SHALL live in the shared defines file.
REQ-021 The FIFO SHALL be a sub-module named vwb_request_fifo, holding the rd, payload, length and valid bits, and exposing per-entry rd/valid to the hazard logic.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Single request rd=5, length=4, data=elements 1..8, RF finishes 1 cycle after WRITE -> WRITE in cycle N+1 with rd=5, length=4; wb_done exactly once; in_ready stays 1.
- Three back-to-back requests rd=1,2,3 with rf_status delayed 3 cycles -> in_ready=0 after the 2nd; writes issued in order 1,2,3; exactly 3 wb_done pulses.
- length=0 request rd=7 -> write_back_enabled never 1; wb_done pulses once; hazard for query_rs=7 clears.
- VWB_MASK_EN, in_mask=8'b0000_0101, in_old=all 0xAAAA_AAAA, in_data=all 0x1 -> data elements 0 and 2 =0x1, others =0xAAAA_AAAA.
- rst=0 asserted during WAIT with 2 entries queued -> all outputs take reset values immediately; no further writes; no wb_done.
- rdy_in=0 for 4 cycles while in WAIT with rf_status=RF_FINISHED -> state holds; retirement occurs in the first cycle after rdy_in returns to 1.
